uart_rx: RTL and testbench

Byte-wide UART receiver, 8N1, LSB first: the receive counterpart of `uart_tx`. Takes the asynchronous serial line from the board pin, synchronises and majority-filters it, and delivers each received byte to the fabric over a valid/ready handshake. Reports framing errors and overruns as single-cycle pulses. Timing is derived directly from the system clock; no `baud_tick` input is needed.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/rx_sync.sv | 33 +++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART receive constants, state encoding and helpers
package uart_rx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Clocks per bit, rounded to nearest so odd ratios do not drift one way
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - rx pin synchroniser, 3-sample majority vote and falling-edge flag
module rx_sync
    import uart_rx_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic rx,
    output logic vote,
    output logic fall
);

    logic       meta;
    logic       rx_s;
    logic [1:0] hist;

    // Two flops for metastability, then two older copies of rx_s for the vote;
    // everything resets to the idle-high line level so reset never looks like a start edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            hist <= 2'b11;
        end else begin
            meta <= rx;
            rx_s <= meta;
            hist <= {hist[0], rx_s};
        end
    end

    assign vote = majority3(rx_s, hist[0], hist[1]);
    assign fall = hist[0] & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready output and error pulses
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    logic             vote;
    logic             fall;

    rx_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       idx, idx_d;
    logic [7:0]       shreg, shreg_d;
    logic [7:0]       data_d;
    logic             valid_d;
    logic             framing_error_d;
    logic             overrun_d;

    rx_sync u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .rx      (rx),
        .vote    (vote),
        .fall    (fall)
    );

    // State and datapath registers; reset abandons any frame in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            data          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            idx           <= idx_d;
            shreg         <= shreg_d;
            data          <= data_d;
            valid         <= valid_d;
            framing_error <= framing_error_d;
            overrun       <= overrun_d;
        end
    end

    // Next-state, bit timing and output handshake
    always_comb begin
        state_d         = state;
        cnt_d           = cnt + CNT_W'(1);
        idx_d           = idx;
        shreg_d         = shreg;
        data_d          = data;
        valid_d         = valid & ~ready;
        framing_error_d = 1'b0;
        overrun_d       = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    if (vote) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    shreg_d[idx] = vote;
                    cnt_d        = '0;
                    idx_d        = idx + 3'd1;
                    if (idx == IDX_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    // Leave at mid-stop so a back-to-back start edge is not missed
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (!vote) begin
                        framing_error_d = 1'b1;
                    end else if (!valid || ready) begin
                        data_d  = shreg;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed testbench for uart_rx
module tb_uart_rx;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       framing_error;
    logic       overrun;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         rise_cyc = -1;
    int         ov_cyc = -1;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic       valid_q = 1'b0;
    logic [7:0] acc[$];

    uart_rx dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rx            (rx),
        .data          (data),
        .valid         (valid),
        .ready         (ready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (valid && !valid_q) rise_cyc = cyc;
        if (valid && ready) acc.push_back(data);
        if (framing_error) fe_cnt++;
        if (overrun) begin
            ov_cnt++;
            ov_cyc = cyc;
        end
        valid_q = valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One 8N1 frame at 104 clocks per bit; glitch_bit >= 0 puts a 1-cycle low pulse mid that data bit
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1 rx = bits[i];
            if (i == 0) fall_cyc = cyc;
            if (glitch_bit >= 0 && i == glitch_bit + 1) begin
                repeat (51) @(posedge clock);
                #1 rx = 1'b0;
                @(posedge clock);
                #1 rx = bits[i];
                repeat (51) @(posedge clock);
            end else begin
                repeat (103) @(posedge clock);
            end
        end
    endtask

    task automatic set_ready(input logic r);
        @(posedge clock);
        #1 ready = r;
    endtask

    initial begin
        reset_n = 1'b0;
        rx      = 1'b1;
        ready   = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rst_valid", valid, 0);
        check("rst_data", data, 8'h00);
        check("rst_fe", framing_error, 0);
        check("rst_ov", overrun, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clock);

        // 0x55 with a glitch at the bit-0 sample point, consumer stalled
        send_frame(8'h55, 1'b1, 0);
        @(negedge clock);
        check("t1_latency", rise_cyc - fall_cyc, 991);
        check("t1_data", data, 8'h55);
        check("t1_flags", fe_cnt + ov_cnt, 0);
        repeat (50) @(posedge clock);
        @(negedge clock);
        check("t1_hold_valid", valid, 1);
        check("t1_hold_data", data, 8'h55);
        set_ready(1'b1);
        @(negedge clock);
        check("t1_valid_pre_accept", valid, 1);
        @(posedge clock);
        #1 check("t1_valid_after", valid, 0);
        check("t1_acc_size", acc.size(), 1);
        check("t1_acc_data", acc[0], 8'h55);

        // Short low pulse is rejected as a glitch, then a real frame
        @(posedge clock);
        #1 rx = 1'b0;
        repeat (30) @(posedge clock);
        #1 rx = 1'b1;
        repeat (300) @(posedge clock);
        @(negedge clock);
        check("t2_no_valid", valid, 0);
        check("t2_no_flags", fe_cnt + ov_cnt, 0);
        check("t2_no_byte", acc.size(), 1);
        send_frame(8'hA3, 1'b1, -1);
        @(negedge clock);
        check("t2_acc_size", acc.size(), 2);
        check("t2_acc_data", acc[1], 8'hA3);

        // Stop bit low then break: one framing error and nothing else
        send_frame(8'h00, 1'b0, -1);
        repeat (2000) @(posedge clock);
        @(negedge clock);
        check("t3_fe_cnt", fe_cnt, 1);
        check("t3_valid", valid, 0);
        check("t3_no_byte", acc.size(), 2);
        @(posedge clock);
        #1 rx = 1'b1;
        repeat (103) @(posedge clock);
        send_frame(8'h7E, 1'b1, -1);
        @(negedge clock);
        check("t3_acc_data", acc[2], 8'h7E);
        check("t3_ov_cnt", ov_cnt, 0);

        // Overrun: second byte arrives while the first is unaccepted
        set_ready(1'b0);
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        @(negedge clock);
        check("t4_ov_cnt", ov_cnt, 1);
        check("t4_ov_time", ov_cyc - fall_cyc, 991);
        check("t4_data", data, 8'h11);
        check("t4_valid", valid, 1);
        set_ready(1'b1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("t4_acc_data", acc[3], 8'h11);
        check("t4_valid_drained", valid, 0);

        // Back-to-back frames with acceptance in the completing cycle
        set_ready(1'b0);
        send_frame(8'h01, 1'b1, -1);
        fork
            send_frame(8'h02, 1'b1, -1);
            begin
                @(posedge clock);
                repeat (990) @(posedge clock);
                #1 ready = 1'b1;
                @(posedge clock);
                #1 ready = 1'b0;
            end
        join
        @(negedge clock);
        check("t5_acc_size", acc.size(), 5);
        check("t5_acc_first", acc[4], 8'h01);
        check("t5_valid", valid, 1);
        check("t5_data", data, 8'h02);
        check("t5_ov_cnt", ov_cnt, 1);
        set_ready(1'b1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("t5_acc_second", acc[5], 8'h02);

        // Reset mid-frame while a byte is held
        set_ready(1'b0);
        send_frame(8'h99, 1'b1, -1);
        @(negedge clock);
        check("t6_pre_valid", valid, 1);
        fork
            send_frame(8'hC3, 1'b1, -1);
            begin
                @(posedge clock);
                repeat (570) @(posedge clock);
                #1 reset_n = 1'b0;
                #1;
                check("t6_rst_valid", valid, 0);
                check("t6_rst_data", data, 8'h00);
                check("t6_rst_flags", {framing_error, overrun}, 2'b00);
            end
        join
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (104) @(posedge clock);
        set_ready(1'b1);
        send_frame(8'h3C, 1'b1, -1);
        @(negedge clock);
        check("t6_acc_size", acc.size(), 7);
        check("t6_acc_data", acc[6], 8'h3C);
        check("t6_fe_cnt", fe_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
